// File: rtl/itlb_ptw_pkg.sv
// itlb_ptw_pkg: shared constants for the ITLB page-table walker.
// Holds the FSM state encoding, PTE field positions, fault causes and the PTE address helper.
package itlb_ptw_pkg;

    localparam int PPN_W = 8;
    localparam int VPN_W = 10;
    localparam int PA_W  = 20;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_L1    = 3'd1;
    localparam logic [2:0] ST_L2    = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;
    localparam logic [2:0] ST_DRAIN = 3'd6;

    localparam int PTE_V       = 0;
    localparam int PTE_R       = 1;
    localparam int PTE_W       = 2;
    localparam int PTE_X       = 3;
    localparam int PTE_PPN_LSB = 10;

    localparam logic [1:0] FC_INVALID   = 2'd0;
    localparam logic [1:0] FC_SUPERPAGE = 2'd1;
    localparam logic [1:0] FC_NONLEAF   = 2'd2;
    localparam logic [1:0] FC_NOEXEC    = 2'd3;

    // Byte address of a 4-byte PTE: table PPN, index, word offset.
    function automatic logic [PA_W-1:0] pte_addr(
        input logic [PPN_W-1:0] ppn,
        input logic [VPN_W-1:0] vpn
    );
        return {ppn, vpn, 2'b00};
    endfunction

endpackage

// File: rtl/itlb_ptw_pte_check.sv
// pte_check: combinational PTE decoder shared by both walk levels.
// Ports: pte_i (raw PTE) -> valid_o, leaf_o (any of R/W/X), exec_o (X), ppn_o.
module pte_check
    import itlb_ptw_pkg::*;
#(
    parameter int PTE_WIDTH = 32,
    parameter int PPN_WIDTH = 8
) (
    input  logic [PTE_WIDTH-1:0] pte_i,
    output logic                 valid_o,
    output logic                 leaf_o,
    output logic                 exec_o,
    output logic [PPN_WIDTH-1:0] ppn_o
);

    logic unused_pte;

    assign valid_o = pte_i[PTE_V];
    assign leaf_o  = pte_i[PTE_R] | pte_i[PTE_W] | pte_i[PTE_X];
    assign exec_o  = pte_i[PTE_X];
    assign ppn_o   = pte_i[PTE_PPN_LSB +: PPN_WIDTH];

    assign unused_pte = ^{pte_i[PTE_WIDTH-1:PTE_PPN_LSB+PPN_WIDTH],
                          pte_i[PTE_PPN_LSB-1:4]};

endmodule

// File: rtl/itlb_ptw.sv
// itlb_ptw: two-level instruction page-table walker behind the ITLB.
// Ports: ITLB request/VA/ptbr/flush in; memory req/addr out, valid/rdata in; refill strobe/PPN and fault strobe out.
module itlb_ptw
    import itlb_ptw_pkg::*;
#(
    parameter int VA_WIDTH          = 32,
    parameter int PC_BITS           = 20,
    parameter int PAGE_OFFSET_WIDTH = 12,
    parameter int PPN_WIDTH         = 8,
    parameter int PTE_WIDTH         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Itlb_pa_request,
    input  logic [VA_WIDTH-1:0]  Itlb_va,
    input  logic [PPN_WIDTH-1:0] ptbr,
    input  logic                 Ptw_flush,
    output logic                 Ptw_mem_req,
    output logic [PC_BITS-1:0]   Ptw_mem_addr,
    input  logic                 Ptw_mem_valid,
    input  logic [PTE_WIDTH-1:0] Ptw_mem_rdata,
    output logic                 F_ptw_valid,
    output logic [PPN_WIDTH-1:0] F_ptw_pa,
    output logic                 Ptw_fault
);

    logic [2:0]           state_q, state_d;
    logic [VPN_W-1:0]     vpn1_q, vpn1_d;
    logic [VPN_W-1:0]     vpn0_q, vpn0_d;
    logic [PPN_WIDTH-1:0] ppn1_q, ppn1_d;
    logic [PPN_WIDTH-1:0] pa_q, pa_d;
    logic [PC_BITS-1:0]   drain_addr_q, drain_addr_d;

    logic                 pte_v;
    logic                 pte_leaf;
    logic                 pte_x;
    logic [PPN_WIDTH-1:0] pte_ppn;
    logic [PC_BITS-1:0]   l1_addr;
    logic [PC_BITS-1:0]   l2_addr;
    logic                 unused_va;

    pte_check #(
        .PTE_WIDTH(PTE_WIDTH),
        .PPN_WIDTH(PPN_WIDTH)
    ) u_pte_check (
        .pte_i  (Ptw_mem_rdata),
        .valid_o(pte_v),
        .leaf_o (pte_leaf),
        .exec_o (pte_x),
        .ppn_o  (pte_ppn)
    );

    assign l1_addr   = pte_addr(ptbr, vpn1_q);
    assign l2_addr   = pte_addr(ppn1_q, vpn0_q);
    assign unused_va = ^Itlb_va[PAGE_OFFSET_WIDTH-1:0];

    // Request and address are pure state decode, so they stay put
    // through every wait cycle up to and including the response.
    always_comb begin
        Ptw_mem_req  = 1'b0;
        Ptw_mem_addr = '0;
        unique case (state_q)
            ST_L1: begin
                Ptw_mem_req  = 1'b1;
                Ptw_mem_addr = l1_addr;
            end
            ST_L2: begin
                Ptw_mem_req  = 1'b1;
                Ptw_mem_addr = l2_addr;
            end
            ST_DRAIN: begin
                Ptw_mem_req  = 1'b1;
                Ptw_mem_addr = drain_addr_q;
            end
            default: ;
        endcase
    end

    assign F_ptw_valid = (state_q == ST_DONE) && !Ptw_flush;
    assign Ptw_fault   = (state_q == ST_FAULT) && !Ptw_flush;
    assign F_ptw_pa    = pa_q;

    always_comb begin
        state_d      = state_q;
        vpn1_d       = vpn1_q;
        vpn0_d       = vpn0_q;
        ppn1_d       = ppn1_q;
        pa_d         = pa_q;
        drain_addr_d = drain_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Itlb_pa_request && !Ptw_flush) begin
                    vpn1_d  = Itlb_va[PAGE_OFFSET_WIDTH+VPN_W +: VPN_W];
                    vpn0_d  = Itlb_va[PAGE_OFFSET_WIDTH +: VPN_W];
                    state_d = ST_L1;
                end
            end
            ST_L1: begin
                if (Ptw_flush) begin
                    // An in-flight read must still be absorbed before
                    // the port can be reused.
                    drain_addr_d = l1_addr;
                    state_d      = Ptw_mem_valid ? ST_IDLE : ST_DRAIN;
                end else if (Ptw_mem_valid) begin
                    if (!pte_v || pte_leaf) begin
                        state_d = ST_FAULT;
                    end else begin
                        ppn1_d  = pte_ppn;
                        state_d = ST_L2;
                    end
                end
            end
            ST_L2: begin
                if (Ptw_flush) begin
                    drain_addr_d = l2_addr;
                    state_d      = Ptw_mem_valid ? ST_IDLE : ST_DRAIN;
                end else if (Ptw_mem_valid) begin
                    if (!pte_v || !pte_leaf || !pte_x) begin
                        state_d = ST_FAULT;
                    end else begin
                        pa_d    = pte_ppn;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = Ptw_flush ? ST_IDLE : ST_HOLD;
            end
            // Wait for the ITLB to drop the faulting request so the
            // same VA is not walked again immediately.
            ST_HOLD: begin
                if (!Itlb_pa_request) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (Ptw_mem_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vpn1_q       <= '0;
            vpn0_q       <= '0;
            ppn1_q       <= '0;
            pa_q         <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            vpn1_q       <= vpn1_d;
            vpn0_q       <= vpn0_d;
            ppn1_q       <= ppn1_d;
            pa_q         <= pa_d;
            drain_addr_q <= drain_addr_d;
        end
    end

endmodule

// File: tb/tb_itlb_ptw.sv
// tb_itlb_ptw: directed testbench for itlb_ptw.
// Drives ITLB and memory sides cycle by cycle with hand-computed expectations.
module tb_itlb_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic        Itlb_pa_request;
    logic [31:0] Itlb_va;
    logic [7:0]  ptbr;
    logic        Ptw_flush;
    logic        Ptw_mem_req;
    logic [19:0] Ptw_mem_addr;
    logic        Ptw_mem_valid;
    logic [31:0] Ptw_mem_rdata;
    logic        F_ptw_valid;
    logic [7:0]  F_ptw_pa;
    logic        Ptw_fault;

    int passed = 0;
    int total  = 0;

    itlb_ptw dut (
        .clk            (clk),
        .rst            (rst),
        .Itlb_pa_request(Itlb_pa_request),
        .Itlb_va        (Itlb_va),
        .ptbr           (ptbr),
        .Ptw_flush      (Ptw_flush),
        .Ptw_mem_req    (Ptw_mem_req),
        .Ptw_mem_addr   (Ptw_mem_addr),
        .Ptw_mem_valid  (Ptw_mem_valid),
        .Ptw_mem_rdata  (Ptw_mem_rdata),
        .F_ptw_valid    (F_ptw_valid),
        .F_ptw_pa       (F_ptw_pa),
        .Ptw_fault      (Ptw_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst             = 1'b1;
        Itlb_pa_request = 1'b0;
        Itlb_va         = 32'h0;
        ptbr            = 8'h01;
        Ptw_flush       = 1'b0;
        Ptw_mem_valid   = 1'b0;
        Ptw_mem_rdata   = 32'h0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        rst = 1'b1;
        #1;
        total++; if (Ptw_mem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", Ptw_mem_req); else passed++;
        total++; if (Ptw_mem_addr !== 20'h0) $display("FAIL rst_addr got %h exp 00000", Ptw_mem_addr); else passed++;
        total++; if (F_ptw_valid !== 1'b0) $display("FAIL rst_fvalid got %b exp 0", F_ptw_valid); else passed++;
        total++; if (F_ptw_pa !== 8'h0) $display("FAIL rst_pa got %h exp 00", F_ptw_pa); else passed++;
        total++; if (Ptw_fault !== 1'b0) $display("FAIL rst_fault got %b exp 0", Ptw_fault); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_normal_walk;
        do_reset();
        ptbr = 8'h01;
        Itlb_va = 32'h0040_3ABC;
        Itlb_pa_request = 1'b1;
        tick();
        total++; if (Ptw_mem_req !== 1'b1) $display("FAIL nw_c1_req got %b exp 1", Ptw_mem_req); else passed++;
        total++; if (Ptw_mem_addr !== 20'h01004) $display("FAIL nw_l1_addr got %h exp 01004", Ptw_mem_addr); else passed++;
        Ptw_mem_valid = 1'b1;
        Ptw_mem_rdata = 32'h0000_0801;
        tick();
        total++; if (Ptw_mem_req !== 1'b1) $display("FAIL nw_c2_req got %b exp 1", Ptw_mem_req); else passed++;
        total++; if (Ptw_mem_addr !== 20'h0200C) $display("FAIL nw_l2_addr got %h exp 0200c", Ptw_mem_addr); else passed++;
        Ptw_mem_rdata = 32'h0001_6809;
        tick();
        Ptw_mem_valid = 1'b0;
        total++; if (F_ptw_valid !== 1'b1) $display("FAIL nw_c3_fvalid got %b exp 1", F_ptw_valid); else passed++;
        total++; if (F_ptw_pa !== 8'h5A) $display("FAIL nw_pa got %h exp 5a", F_ptw_pa); else passed++;
        total++; if (Ptw_mem_req !== 1'b0) $display("FAIL nw_c3_req got %b exp 0", Ptw_mem_req); else passed++;
        Itlb_pa_request = 1'b0;
        tick();
        total++; if (F_ptw_valid !== 1'b0) $display("FAIL nw_c4_fvalid got %b exp 0", F_ptw_valid); else passed++;
        total++; if (F_ptw_pa !== 8'h5A) $display("FAIL nw_pa_hold got %h exp 5a", F_ptw_pa); else passed++;
        total++; if (Ptw_mem_req !== 1'b0) $display("FAIL nw_c4_req got %b exp 0", Ptw_mem_req); else passed++;
    endtask

    task automatic test_l1_invalid_hold;
        do_reset();
        Itlb_va = 32'h0040_3ABC;
        Itlb_pa_request = 1'b1;
        tick();
        Ptw_mem_valid = 1'b1;
        Ptw_mem_rdata = 32'h0;
        tick();
        Ptw_mem_valid = 1'b0;
        total++; if (Ptw_fault !== 1'b1) $display("FAIL inv_fault got %b exp 1", Ptw_fault); else passed++;
        total++; if (Ptw_mem_req !== 1'b0) $display("FAIL inv_no_l2 got %b exp 0", Ptw_mem_req); else passed++;
        tick();
        total++; if (Ptw_fault !== 1'b0) $display("FAIL inv_fault_1cyc got %b exp 0", Ptw_fault); else passed++;
        tick();
        tick();
        total++; if (Ptw_mem_req !== 1'b0) $display("FAIL inv_hold_req got %b exp 0", Ptw_mem_req); else passed++;
        Itlb_pa_request = 1'b0;
        tick();
        Itlb_pa_request = 1'b1;
        tick();
        total++; if (Ptw_mem_req !== 1'b1) $display("FAIL inv_rewalk_req got %b exp 1", Ptw_mem_req); else passed++;
        total++; if (Ptw_mem_addr !== 20'h01004) $display("FAIL inv_rewalk_addr got %h exp 01004", Ptw_mem_addr); else passed++;
    endtask

    task automatic test_leaf_faults;
        do_reset();
        Itlb_va = 32'h0040_3ABC;
        Itlb_pa_request = 1'b1;
        tick();
        Ptw_mem_valid = 1'b1;
        Ptw_mem_rdata = 32'h0000_0809;
        tick();
        Ptw_mem_valid = 1'b0;
        total++; if (Ptw_fault !== 1'b1) $display("FAIL l1leaf_fault got %b exp 1", Ptw_fault); else passed++;
        total++; if (Ptw_mem_req !== 1'b0) $display("FAIL l1leaf_req got %b exp 0", Ptw_mem_req); else passed++;
        Itlb_pa_request = 1'b0;
        tick();
        tick();
        Itlb_pa_request = 1'b1;
        tick();
        Ptw_mem_valid = 1'b1;
        Ptw_mem_rdata = 32'h0000_0801;
        tick();
        total++; if (Ptw_mem_addr !== 20'h0200C) $display("FAIL nx_l2_addr got %h exp 0200c", Ptw_mem_addr); else passed++;
        Ptw_mem_rdata = 32'h0001_6803;
        tick();
        Ptw_mem_valid = 1'b0;
        total++; if (Ptw_fault !== 1'b1) $display("FAIL nx_fault got %b exp 1", Ptw_fault); else passed++;
        total++; if (F_ptw_valid !== 1'b0) $display("FAIL nx_fvalid got %b exp 0", F_ptw_valid); else passed++;
        tick();
        total++; if (F_ptw_valid !== 1'b0) $display("FAIL nx_fvalid2 got %b exp 0", F_ptw_valid); else passed++;
        total++; if (Ptw_fault !== 1'b0) $display("FAIL nx_fault2 got %b exp 0", Ptw_fault); else passed++;
    endtask

    task automatic test_flush_drain;
        do_reset();
        Itlb_va = 32'h0040_3ABC;
        Itlb_pa_request = 1'b1;
        tick();
        Ptw_flush = 1'b1;
        Itlb_pa_request = 1'b0;
        tick();
        Ptw_flush = 1'b0;
        total++; if (Ptw_mem_req !== 1'b1) $display("FAIL dr_req1 got %b exp 1", Ptw_mem_req); else passed++;
        total++; if (Ptw_mem_addr !== 20'h01004) $display("FAIL dr_addr1 got %h exp 01004", Ptw_mem_addr); else passed++;
        tick();
        total++; if (Ptw_mem_addr !== 20'h01004) $display("FAIL dr_addr2 got %h exp 01004", Ptw_mem_addr); else passed++;
        Ptw_mem_valid = 1'b1;
        Ptw_mem_rdata = 32'h0000_0801;
        tick();
        Ptw_mem_valid = 1'b0;
        total++; if (Ptw_mem_req !== 1'b0) $display("FAIL dr_idle_req got %b exp 0", Ptw_mem_req); else passed++;
        total++; if ({F_ptw_valid, Ptw_fault} !== 2'b00) $display("FAIL dr_strobes got %b exp 00", {F_ptw_valid, Ptw_fault}); else passed++;
        Itlb_va = 32'h0080_3000;
        Itlb_pa_request = 1'b1;
        tick();
        total++; if (Ptw_mem_req !== 1'b1) $display("FAIL dr_new_req got %b exp 1", Ptw_mem_req); else passed++;
        total++; if (Ptw_mem_addr !== 20'h01008) $display("FAIL dr_new_addr got %h exp 01008", Ptw_mem_addr); else passed++;
    endtask

    task automatic test_flush_same_cycle;
        do_reset();
        Itlb_va = 32'h0040_3ABC;
        Itlb_pa_request = 1'b1;
        tick();
        Ptw_mem_valid = 1'b1;
        Ptw_mem_rdata = 32'h0000_0801;
        tick();
        Ptw_mem_rdata = 32'h0001_6809;
        Ptw_flush = 1'b1;
        Itlb_pa_request = 1'b0;
        tick();
        Ptw_flush = 1'b0;
        Ptw_mem_valid = 1'b0;
        total++; if (F_ptw_valid !== 1'b0) $display("FAIL fs_fvalid got %b exp 0", F_ptw_valid); else passed++;
        total++; if (Ptw_mem_req !== 1'b0) $display("FAIL fs_req got %b exp 0", Ptw_mem_req); else passed++;
        total++; if (F_ptw_pa !== 8'h00) $display("FAIL fs_pa got %h exp 00", F_ptw_pa); else passed++;
    endtask

    task automatic test_flush_fault;
        do_reset();
        Itlb_va = 32'h0040_3ABC;
        Itlb_pa_request = 1'b1;
        tick();
        Ptw_mem_valid = 1'b1;
        Ptw_mem_rdata = 32'h0;
        tick();
        Ptw_mem_valid = 1'b0;
        Ptw_flush = 1'b1;
        #1;
        total++; if (Ptw_fault !== 1'b0) $display("FAIL ff_fault got %b exp 0", Ptw_fault); else passed++;
        tick();
        Ptw_flush = 1'b0;
        total++; if (Ptw_mem_req !== 1'b0) $display("FAIL ff_idle_req got %b exp 0", Ptw_mem_req); else passed++;
        tick();
        total++; if (Ptw_mem_req !== 1'b1) $display("FAIL ff_no_hold got %b exp 1", Ptw_mem_req); else passed++;
    endtask

    task automatic test_wait_states;
        logic [19:0] exp_addr;
        do_reset();
        Itlb_va = 32'h0040_3ABC;
        Itlb_pa_request = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            exp_addr = (c <= 4) ? 20'h01004 : 20'h0200C;
            total++; if (Ptw_mem_addr !== exp_addr || Ptw_mem_req !== 1'b1 || F_ptw_valid !== 1'b0)
                $display("FAIL ws_c%0d got req %b addr %h fv %b exp 1 %h 0", c, Ptw_mem_req, Ptw_mem_addr, F_ptw_valid, exp_addr);
            else passed++;
            Ptw_mem_valid = (c == 4) || (c == 8);
            Ptw_mem_rdata = (c == 4) ? 32'h0000_0801 : 32'h0001_6809;
            tick();
        end
        Ptw_mem_valid = 1'b0;
        total++; if (F_ptw_valid !== 1'b1) $display("FAIL ws_c9_fvalid got %b exp 1", F_ptw_valid); else passed++;
        total++; if (F_ptw_pa !== 8'h5A) $display("FAIL ws_pa got %h exp 5a", F_ptw_pa); else passed++;
        Itlb_pa_request = 1'b0;
        tick();
    endtask

    task automatic test_async_reset;
        do_reset();
        Itlb_va = 32'h0040_3ABC;
        Itlb_pa_request = 1'b1;
        tick();
        Ptw_mem_valid = 1'b1;
        Ptw_mem_rdata = 32'h0000_0801;
        tick();
        Ptw_mem_valid = 1'b0;
        total++; if (Ptw_mem_addr !== 20'h0200C) $display("FAIL ar_in_l2 got %h exp 0200c", Ptw_mem_addr); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (Ptw_mem_req !== 1'b0) $display("FAIL ar_req got %b exp 0", Ptw_mem_req); else passed++;
        total++; if (Ptw_mem_addr !== 20'h0) $display("FAIL ar_addr got %h exp 00000", Ptw_mem_addr); else passed++;
        rst = 1'b0;
        Itlb_pa_request = 1'b0;
        Ptw_mem_valid = 1'b1;
        Ptw_mem_rdata = 32'h0001_6809;
        tick();
        Ptw_mem_valid = 1'b0;
        total++; if ({F_ptw_valid, Ptw_fault, Ptw_mem_req} !== 3'b000) $display("FAIL ar_late_valid got %b exp 000", {F_ptw_valid, Ptw_fault, Ptw_mem_req}); else passed++;
        total++; if (F_ptw_pa !== 8'h00) $display("FAIL ar_pa got %h exp 00", F_ptw_pa); else passed++;
    endtask

    initial begin
        test_reset();
        test_normal_walk();
        test_l1_invalid_hold();
        test_leaf_faults();
        test_flush_drain();
        test_flush_same_cycle();
        test_flush_fault();
        test_wait_states();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
